hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. Consumes ID-stage register usage and the
//  EX-stage control bundle produced by the decoder (memory_rw, register_write, branch

---
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_controller.sv | 139 +++++++++++++
 tb/tb_hazard_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline hazard control bundle: ID/EX/MEM status in, pipeline enables,
// bubbles, flushes and performance counters out.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  // Status from the pipeline
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic [1:0]       ex_memory_rw;
  logic             ex_register_write;
  logic             ex_branch_taken;
  logic             mem_valid;
  logic             mem_ready;
  // Control back to the pipeline
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_hold;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  // Pipeline side
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memory_rw,
           ex_register_write, ex_branch_taken, mem_valid, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_wb_bubble, stall_cycles, flush_count, mem_timeout
  );

  // Hazard controller side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memory_rw,
           ex_register_write, ex_branch_taken, mem_valid, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           mem_wb_bubble, stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use stalls, taken-branch
// flushes, data-memory wait states, plus stall/flush performance counters.
module hazard_controller #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.slave  hz
);

  // memory_rw encodings shared with the decoder
  localparam logic [1:0]  M_X = 2'd0;
  localparam logic [1:0]  M_R = 2'd1;
  localparam logic [1:0]  M_W = 2'd2;

  localparam logic [3:0]  LAT_M1  = 4'(LOAD_LAT - 1);
  localparam logic [15:0] TO_LIM  = 16'(MEM_TIMEOUT);
  localparam logic [15:0] WAIT_MX = 16'hFFFF;

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} state_t;

  state_t      state_q, state_d, ret_q, ret_d, eff_state;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] wait_q, wait_d;
  logic        mem_wait, load_use, flush_inc;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble;

  assign mem_wait = hz.mem_valid & ~hz.mem_ready;
  assign load_use = (hz.ex_memory_rw == M_R) & hz.ex_register_write & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // While parked in MEM_WAIT, a cycle without a wait behaves as the saved state,
  // so the ready cycle already does useful work (e.g. consumes a load stall).
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  // Next state and same-cycle pipeline control
  always_comb begin
    // NOTE: every output and next-state term gets a default first so no path infers a latch.
    state_d       = state_q;
    ret_d         = ret_q;
    rem_d         = rem_q;
    wait_d        = '0;
    flush_inc     = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_hold     = 1'b0;
    mem_wb_bubble = 1'b0;

    if (mem_wait) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_hold     = 1'b1;
      mem_wb_bubble = 1'b1;
      state_d       = MEM_WAIT;
      ret_d         = eff_state;
      wait_d        = (wait_q == WAIT_MX) ? wait_q : wait_q + 16'd1;
    end else begin
      case (eff_state)
        LD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (rem_q <= 4'd1) begin
            state_d = RUN;
            rem_d   = '0;
          end else begin
            state_d = LD_STALL;
            rem_d   = rem_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          if (hz.ex_branch_taken) begin
            // ID is flushed, so a coincident load-use no longer matters
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LD_STALL;
              rem_d   = LAT_M1;
            end
          end
        end
      endcase
    end

    // NOTE: reset also forces the combinational controls, since they must show
    // their reset values while rst_n is low, not only after the next edge.
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b1;
      pipe_hold     = 1'b0;
      mem_wb_bubble = 1'b1;
      flush_inc     = 1'b0;
    end
  end

  // State, wait tracking, counters and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      ret_q           <= RUN;
      rem_q           <= '0;
      wait_q          <= '0;
      hz.stall_cycles <= '0;
      hz.flush_count  <= '0;
      hz.mem_timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      if (!pc_write)                       hz.stall_cycles <= hz.stall_cycles + 1'b1;
      if (flush_inc)                       hz.flush_count  <= hz.flush_count + 1'b1;
      if (mem_wait && (wait_d >= TO_LIM))  hz.mem_timeout  <= 1'b1;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.pipe_hold     = pipe_hold;
  assign hz.mem_wb_bubble = mem_wb_bubble;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: two controllers (LOAD_LAT 1 and 3, MEM_TIMEOUT 4) share
// the same stimulus and are compared cycle by cycle with a reference model.
module tb_hazard_controller;

  localparam logic [1:0] M_X = 2'd0;
  localparam logic [1:0] M_R = 2'd1;
  localparam logic [1:0] M_W = 2'd2;
  localparam int         TO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(32)) ifa ();
  hazard_controller_if #(.CNT_W(32)) ifb ();

  hazard_controller #(.LOAD_LAT(1), .MEM_TIMEOUT(TO), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
  hazard_controller #(.LOAD_LAT(3), .MEM_TIMEOUT(TO), .CNT_W(32)) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

  // Shared stimulus
  logic [4:0] t_rs1, t_rs2, t_rd;
  logic       t_u1, t_u2, t_rw, t_br, t_mv, t_mr;
  logic [1:0] t_mrw;

  assign ifa.id_rs1 = t_rs1;  assign ifb.id_rs1 = t_rs1;
  assign ifa.id_rs2 = t_rs2;  assign ifb.id_rs2 = t_rs2;
  assign ifa.id_uses_rs1 = t_u1;  assign ifb.id_uses_rs1 = t_u1;
  assign ifa.id_uses_rs2 = t_u2;  assign ifb.id_uses_rs2 = t_u2;
  assign ifa.ex_rd = t_rd;  assign ifb.ex_rd = t_rd;
  assign ifa.ex_memory_rw = t_mrw;  assign ifb.ex_memory_rw = t_mrw;
  assign ifa.ex_register_write = t_rw;  assign ifb.ex_register_write = t_rw;
  assign ifa.ex_branch_taken = t_br;  assign ifb.ex_branch_taken = t_br;
  assign ifa.mem_valid = t_mv;  assign ifb.mem_valid = t_mv;
  assign ifa.mem_ready = t_mr;  assign ifb.mem_ready = t_mr;

  // Observed values, index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 3
  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble}
  logic [5:0]  ctl [2];
  logic [31:0] sc  [2];
  logic [31:0] fc  [2];
  logic        tmo [2];
  assign ctl[0] = {ifa.pc_write, ifa.if_id_write, ifa.if_id_flush, ifa.id_ex_bubble, ifa.pipe_hold, ifa.mem_wb_bubble};
  assign ctl[1] = {ifb.pc_write, ifb.if_id_write, ifb.if_id_flush, ifb.id_ex_bubble, ifb.pipe_hold, ifb.mem_wb_bubble};
  assign sc[0] = ifa.stall_cycles;  assign sc[1] = ifb.stall_cycles;
  assign fc[0] = ifa.flush_count;   assign fc[1] = ifb.flush_count;
  assign tmo[0] = ifa.mem_timeout; assign tmo[1] = ifb.mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stall cycles still owed, consecutive wait run, counters
  int m_lat   [2] = '{1, 3};
  int m_left  [2];
  int m_wait  [2];
  int m_stall [2];
  int m_flush [2];
  bit m_to    [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_to[k] = 0;
    end
  endfunction

  task automatic model_step(input int k, output logic [5:0] exp);
    bit lu;
    lu = (t_mrw == M_R) && t_rw && (t_rd != 0) &&
         ((t_u1 && t_rs1 == t_rd) || (t_u2 && t_rs2 == t_rd));
    if (t_mv && !t_mr) begin
      exp = 6'b000011;
      m_wait[k]++;
      if (m_wait[k] >= TO) m_to[k] = 1;
      m_stall[k]++;
    end else begin
      m_wait[k] = 0;
      if (m_left[k] > 0) begin
        exp = 6'b000100; m_left[k]--; m_stall[k]++;
      end else if (t_br) begin
        exp = 6'b101100; m_flush[k]++;
      end else if (lu) begin
        exp = 6'b000100; m_left[k] = m_lat[k] - 1; m_stall[k]++;
      end else begin
        exp = 6'b110000;
      end
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs applied
  task automatic step();
    logic [5:0] e;
    #3;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall_cycles[%0d]", k), sc[k], 32'(m_stall[k]));
      check($sformatf("flush_count[%0d]", k),  fc[k], 32'(m_flush[k]));
      check($sformatf("mem_timeout[%0d]", k),  32'(tmo[k]), 32'(m_to[k]));
      model_step(k, e);
      check($sformatf("ctl[%0d]", k), 32'(ctl[k]), 32'(e));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    t_rs1 = 0; t_rs2 = 0; t_u1 = 0; t_u2 = 0; t_rd = 0; t_mrw = M_X;
    t_rw = 0; t_br = 0; t_mv = 0; t_mr = 1;
  endtask

  // ex: LW x5 ; id: ADD uses rs2=x5
  task automatic load_use_in(input logic [4:0] rd, input logic [1:0] mrw);
    idle();
    t_rd = rd; t_mrw = mrw; t_rw = 1; t_rs1 = 5'd7; t_u1 = 1; t_rs2 = 5'd5; t_u2 = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ctl[%0d]", k), 32'(ctl[k]), 32'h05);
      check($sformatf("rst_stall[%0d]", k), sc[k], 0);
      check($sformatf("rst_flush[%0d]", k), fc[k], 0);
      check($sformatf("rst_tmo[%0d]", k), 32'(tmo[k]), 0);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Idle after release, then a single load-use hazard
    step(); step();
    load_use_in(5'd5, M_R); step();
    idle(); repeat (4) step();
    check("lat1_stall", sc[0], 1);
    check("lat3_stall", sc[1], 3);

    // rd = x0 and a store in EX: no hazard
    do_reset();
    load_use_in(5'd0, M_R); step();
    load_use_in(5'd5, M_W); step();
    idle(); repeat (3) step();
    check("nohaz_stall_a", sc[0], 0);
    check("nohaz_stall_b", sc[1], 0);

    // Load-use followed by a two-cycle memory wait in stall cycle 2
    do_reset();
    load_use_in(5'd5, M_R); step();
    idle(); t_mv = 1; t_mr = 0; step(); step();
    idle(); repeat (4) step();
    check("wait_stall_a", sc[0], 3);
    check("wait_stall_b", sc[1], 5);

    // Branch taken together with a load-use: flush, no stall
    do_reset();
    load_use_in(5'd5, M_R); t_br = 1; step();
    idle(); repeat (3) step();
    check("br_flush_a", fc[0], 1);
    check("br_flush_b", fc[1], 1);
    check("br_stall_b", sc[1], 0);

    // Six-cycle memory wait trips the timeout, which stays set
    do_reset();
    idle(); t_mv = 1; t_mr = 0; repeat (6) step();
    idle(); repeat (3) step();
    check("tmo_sticky_a", 32'(tmo[0]), 1);
    check("tmo_sticky_b", 32'(tmo[1]), 1);
    check("tmo_stall_b", sc[1], 6);

    // Randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      t_rs1 = 5'($urandom_range(3));
      t_rs2 = 5'($urandom_range(3));
      t_rd  = 5'($urandom_range(3));
      t_u1  = 1'($urandom_range(1));
      t_u2  = 1'($urandom_range(1));
      t_mrw = 2'($urandom_range(3));
      t_rw  = ($urandom_range(3) != 0);
      t_br  = ($urandom_range(6) == 0);
      t_mv  = ($urandom_range(2) == 0);
      t_mr  = ($urandom_range(2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
